peripheral_bus: RTL and testbench
=================================

PERIPHERAL_BUS -- requirements
Module: peripheral_bus

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports named clk and reset.
REQ-002 Port clk, input, 1 bit: system clock; all state updates on the rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous active-low reset.
REQ-004 Port rd, input, 1 bit: CPU data-bus read strobe (MemRd).
REQ-005 Port wr, input, 1 bit: CPU data-bus write strobe (MemWr).
REQ-006 Port addr, input, 32 bits: byte address from the CPU ALU result.
REQ-007 Port wdata, input, 32 bits: write data from the CPU register operand.
REQ-008 Port rdata, output, 32 bits: combinational read data to the CPU writeback mux.
REQ-009 Port switch, input, 8 bits: board switches.
REQ-010 Port led, output, 8 bits: board LEDs.
REQ-011 Port digi, output, 12 bits: 7-segment drive, {anode[3:0], segment[7:0]}.
REQ-012 Port irq, output, 1 bit: timer interrupt request to the control unit (IRQ).

Function
REQ-013 The block SHALL be the responder end of the CPU data-memory bus for the I/O window 0x4000_0000-0x4000_001F.
- Register map, word-aligned (addr[1:0] ignored):
  - TH at 0x00, RW, 32 bits.
  - TL at 0x04, RW, 32 bits.
  - TCON at 0x08, RW, 3 bits: bit0 = enable, bit1 = irq enable, bit2 = irq status.
  - LED at 0x0C, RW, 8 bits.
  - SWITCH at 0x10, RO, 8 bits.
  - DIGI at 0x14, RW, 12 bits.
  - SYSTICK at 0x18, RO, 32 bits.
REQ-014 A write SHALL take effect on the rising edge where wr=1 and addr selects an RW register; writes to RO registers, unmapped offsets or addresses outside the window SHALL be ignored.
REQ-015 Narrow registers SHALL take wdata LSBs on write, and SHALL zero-extend on read.
REQ-016 rdata SHALL equal the selected register's value in the same cycle (zero latency) when rd=1 and the address is mapped; otherwise rdata SHALL be 0.
REQ-017 When TCON[0]=1, TL SHALL increment by 1 every cycle.
REQ-018 When TCON[0]=1 and TL=0xFFFF_FFFF, TL SHALL load TH instead of wrapping to 0; if TCON[1]=1, TCON[2] SHALL be set on that edge.
REQ-019 TCON[2] SHALL be sticky: it is cleared only by a CPU write of 0 to bit2, or by reset.
REQ-020 irq SHALL equal TCON[1] & TCON[2] (combinational from registers, no added latency).
REQ-021 Simultaneous CPU write to TL and timer increment/reload SHALL resolve to the CPU write.
REQ-022 Simultaneous CPU write to TCON and overflow set SHALL resolve to the CPU write value.
REQ-023 TCON[0]=0 SHALL freeze TL and TCON[2]; TH SHALL never change except by CPU write.
REQ-024 SYSTICK SHALL increment every cycle unconditionally, wrapping 0xFFFF_FFFF to 0.
REQ-025 led SHALL be driven directly by the LED register, and digi directly by the DIGI register.
REQ-026 The SWITCH read value SHALL be the switch input sampled combinationally.
REQ-027 rd and wr asserted together SHALL perform the write at the edge and return pre-edge data on rdata.

Reset
REQ-028 On reset=0, TH, TL, TCON, LED, DIGI and SYSTICK SHALL clear to 0 asynchronously; led=0, digi=0 and irq=0 immediately.
REQ-029 Reset asserted mid-count SHALL abort the count and clear TCON[2] with no pending interrupt.
REQ-030 After reset deasserts, the first update SHALL occur on the next rising edge.

Verification
REQ-031 Write TH=0xFFFF_FFFC, then TL=0xFFFF_FFFE, then TCON=3 -> TL=0xFFFF_FFFF one cycle later, then TL=0xFFFF_FFFC with TCON=7 and irq=1; irq SHALL stay 1 until a TCON write of 3 returns irq=0.
REQ-032 Repeat REQ-031 with TCON=1 -> the reload still occurs, TCON[2] stays 0 and irq stays 0.
REQ-033 Same-cycle TL write 0x10 as TL reaches 0xFFFF_FFFF -> TL=0x10 and TCON[2] is unchanged.
REQ-034 Write LED=0x1A5 and DIGI=0xF3FF, then read both -> led=0xA5, rdata=0xA5; digi=0x3FF, rdata=0x3FF. With switch=0x5C, a read of 0x10 -> rdata=0x5C; a read of 0x1C or 0x3000_0000 -> rdata=0.
REQ-035 Assert reset while TL is counting and irq=1 -> all outputs are 0 before the next edge; SYSTICK reads 0 right after release and 5 after five edges.

Source files
------------

// File: rtl/peripheral_bus.sv
// peripheral_bus: memory-mapped timer, LED, switch, 7-segment and systick responder for the CPU I/O window
module peripheral_bus (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [7:0]  switch,
    output logic [7:0]  led,
    output logic [11:0] digi,
    output logic        irq
);
    logic [31:0] th, tl, systick;
    logic [2:0]  tcon;
    logic [7:0]  led_r;
    logic [11:0] digi_r;
    logic        hit, we_tl, ovf;
    logic [2:0]  off;
    logic        unused_lsb;

    assign hit        = addr[31:5] == 27'h200_0000;
    assign off        = addr[4:2];
    assign unused_lsb = &{1'b0, addr[1:0]};
    assign we_tl      = wr && hit && off == 3'd1;
    // a CPU write to TL cancels the reload and the status set on the same edge
    assign ovf        = tcon[0] && &tl && !we_tl;
    assign irq        = tcon[1] & tcon[2];
    assign led        = led_r;
    assign digi       = digi_r;

    // timer: TL counts up and reloads from TH; CPU writes win over the timer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (wr && hit && off == 3'd0) th <= wdata;
            if (we_tl) tl <= wdata;
            else if (tcon[0]) tl <= &tl ? th : tl + 32'd1;
            if (wr && hit && off == 3'd2) tcon <= wdata[2:0];
            else if (ovf && tcon[1]) tcon[2] <= 1'b1;
        end
    end

    // free-running systick plus the LED and 7-segment output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            systick <= '0;
            led_r   <= '0;
            digi_r  <= '0;
        end else begin
            systick <= systick + 32'd1;
            if (wr && hit && off == 3'd3) led_r <= wdata[7:0];
            if (wr && hit && off == 3'd5) digi_r <= wdata[11:0];
        end
    end

    // zero-latency read mux; unmapped or idle reads return 0
    always_comb begin
        rdata = '0;
        if (rd && hit)
            case (off)
                3'd0:    rdata = th;
                3'd1:    rdata = tl;
                3'd2:    rdata = {29'd0, tcon};
                3'd3:    rdata = {24'd0, led_r};
                3'd4:    rdata = {24'd0, switch};
                3'd5:    rdata = {20'd0, digi_r};
                3'd6:    rdata = systick;
                default: rdata = '0;
            endcase
    end
endmodule

// File: tb/tb_peripheral_bus.sv
// tb_peripheral_bus: directed self-checking bench for peripheral_bus
module tb_peripheral_bus;
    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_SW   = 32'h4000_0010;
    localparam logic [31:0] A_DIGI = 32'h4000_0014;
    localparam logic [31:0] A_TICK = 32'h4000_0018;

    logic        clk = 1'b0;
    logic        reset, rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic [7:0]  switch, led;
    logic [11:0] digi;
    logic        irq;
    int          n_chk = 0;
    int          n_fail = 0;

    peripheral_bus dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .switch(switch), .led(led), .digi(digi), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        rd   = 1'b1;
        #1;
        chk(tag, rdata, exp);
        rd = 1'b0;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; switch = 8'h5C;
        #2;
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_digi", 32'(digi), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        #1 reset = 1'b1;
        tick(1);
        // timer reload with interrupt
        wr_reg(A_TH, 32'hFFFF_FFFC);
        wr_reg(A_TL, 32'hFFFF_FFFE);
        wr_reg(A_TCON, 32'd3);
        rd_chk("tl_start", A_TL, 32'hFFFF_FFFE);
        rd_chk("th_val", A_TH, 32'hFFFF_FFFC);
        tick(1);
        rd_chk("tl_max", A_TL, 32'hFFFF_FFFF);
        chk("irq_pre", 32'(irq), 32'h0);
        tick(1);
        rd_chk("tl_reload", A_TL, 32'hFFFF_FFFC);
        rd_chk("tcon_set", A_TCON, 32'd7);
        chk("irq_set", 32'(irq), 32'h1);
        tick(1);
        chk("irq_sticky", 32'(irq), 32'h1);
        rd_chk("tl_run", A_TL, 32'hFFFF_FFFD);
        wr_reg(A_TCON, 32'd3);
        chk("irq_clr", 32'(irq), 32'h0);
        rd_chk("tcon_clr", A_TCON, 32'd3);
        wr_reg(A_TCON, 32'd0);
        tick(2);
        rd_chk("tl_frozen", A_TL, 32'hFFFF_FFFF);
        rd_chk("tcon_off", A_TCON, 32'd0);
        chk("irq_off", 32'(irq), 32'h0);
        // reload without interrupt enable
        wr_reg(A_TL, 32'hFFFF_FFFE);
        wr_reg(A_TCON, 32'd1);
        tick(2);
        rd_chk("tl_reload_noirq", A_TL, 32'hFFFF_FFFC);
        rd_chk("tcon_noirq", A_TCON, 32'd1);
        chk("irq_noirq", 32'(irq), 32'h0);
        wr_reg(A_TCON, 32'd0);
        // CPU write to TL beats the overflow
        wr_reg(A_TL, 32'hFFFF_FFFE);
        wr_reg(A_TCON, 32'd3);
        tick(1);
        rd_chk("tl_ff", A_TL, 32'hFFFF_FFFF);
        wr_reg(A_TL, 32'h10);
        rd_chk("tl_cpu_wins", A_TL, 32'h10);
        rd_chk("tcon_no_ovf", A_TCON, 32'd3);
        chk("irq_no_ovf", 32'(irq), 32'h0);
        tick(1);
        rd_chk("tl_inc", A_TL, 32'h11);
        wr_reg(A_TCON, 32'd0);
        rd_chk("th_stable", A_TH, 32'hFFFF_FFFC);
        // LED, DIGI, SWITCH and decode
        wr_reg(A_LED, 32'h1A5);
        chk("led_out", 32'(led), 32'hA5);
        rd_chk("led_rd", A_LED, 32'hA5);
        rd_chk("led_rd_unaligned", 32'h4000_000F, 32'hA5);
        wr_reg(A_DIGI, 32'hF3FF);
        chk("digi_out", 32'(digi), 32'h3FF);
        rd_chk("digi_rd", A_DIGI, 32'h3FF);
        rd_chk("sw_rd", A_SW, 32'h5C);
        tick(1);
        rd_chk("unmapped_1c", 32'h4000_001C, 32'h0);
        rd_chk("outside", 32'h3000_0000, 32'h0);
        switch = 8'hA3;
        rd_chk("sw_rd2", A_SW, 32'hA3);
        wr_reg(32'h3000_000C, 32'hFF);
        chk("led_outside_wr", 32'(led), 32'hA5);
        wr_reg(A_SW, 32'hFF);
        rd_chk("sw_ro", A_SW, 32'hA3);
        addr = A_LED;
        #1 chk("rd_idle", rdata, 32'h0);
        // simultaneous read and write
        wdata = 32'h33; rd = 1'b1; wr = 1'b1;
        #1 chk("rw_old", rdata, 32'hA5);
        @(posedge clk);
        #1 wr = 1'b0;
        chk("rw_new", rdata, 32'h33);
        chk("rw_led", 32'(led), 32'h33);
        rd = 1'b0;
        // reset mid-count with irq pending
        wr_reg(A_TH, 32'h0);
        wr_reg(A_TL, 32'hFFFF_FFFE);
        wr_reg(A_TCON, 32'd3);
        tick(2);
        chk("irq_before_rst", 32'(irq), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("rst_led2", 32'(led), 32'h0);
        chk("rst_digi2", 32'(digi), 32'h0);
        chk("rst_irq2", 32'(irq), 32'h0);
        rd_chk("rst_tcon", A_TCON, 32'd0);
        rd_chk("rst_tl", A_TL, 32'd0);
        reset = 1'b1;
        rd_chk("tick0", A_TICK, 32'd0);
        tick(5);
        rd_chk("tick5", A_TICK, 32'd5);
        rd_chk("tl_after_rst", A_TL, 32'd0);
        chk("irq_after_rst", 32'(irq), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
